dma_desc_scheduler: RTL and testbench
=====================================

Name: dma_desc_scheduler

Overview:
- Sequences the DMA datapath from software descriptors (source address, destination address, length, ID).
- Splits each descriptor into chunks and pushes matched read/write commands into the read block and write block command FIFOs, honouring their full flags.
- Counts write-block completions and reports per-descriptor done.
- Sits between the CSR descriptor queue and the read/write blocks.

Parameters:
MAX_CHUNK_BYTES, 1024, maximum bytes per issued command pair; power of two, multiple of 32, at most 1024.
MAX_OUTSTANDING, 8, maximum issued-but-uncompleted chunks; at most 15.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
desc_valid_i  in  1  descriptor available
desc_ready_o  out  1  descriptor accepted this cycle (valid&ready)
desc_src_addr_i  in  32  source byte address
desc_dst_addr_i  in  32  destination byte address
desc_length_i  in  16  byte length; 0 is legal
desc_id_i  in  8  descriptor tag
run_i  in  1  enable; 0 stops new chunk issue
dma_rd_fifo_command_req_o  out  1  read command push
dma_rd_addr_o  out  32  read chunk address
dma_rd_bytes_to_transfer_o  out  16  read chunk bytes
dma_rd_fifo_full_i  in  1  read command FIFO full
dma_wr_fifo_command_req_o  out  1  write command push
dma_wr_addr_o  out  32  write chunk address
dma_wr_bytes_to_transfer_o  out  16  write chunk bytes
dma_wr_fifo_full_i  in  1  write command FIFO full
wr_chunk_done_i  in  1  one-cycle pulse per completed write chunk
desc_done_o  out  1  one-cycle done pulse
desc_done_id_o  out  8  ID of completed descriptor
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; outstanding and issued counters cleared. Reset mid-descriptor abandons it with no done pulse.
- States: IDLE, LOAD, CHECK, ISSUE, DRAIN, REPORT.
- IDLE: desc_ready_o = run_i & desc_valid_i (combinational). Acceptance registers src, dst, remaining=length, id, issued=0 -> LOAD.
- LOAD: chunk = min(remaining, MAX_CHUNK_BYTES), registered. Remaining 0 -> REPORT with no commands issued. Otherwise -> CHECK.
- CHECK: go to ISSUE only when run_i, ~dma_rd_fifo_full_i, ~dma_wr_fifo_full_i, and outstanding < MAX_OUTSTANDING all hold; else stay.
- ISSUE: exactly one cycle with both command reqs high together and identical byte counts (rd addr = src, wr addr = dst). Registered update: src += chunk, dst += chunk, remaining -= chunk, issued += 1, outstanding += 1. Remaining after update 0 -> DRAIN; else -> LOAD.
- Read and write pushes are never split; both fifo fulls are sampled in the same CHECK cycle.
- DRAIN: wait until outstanding == 0 -> REPORT.
- REPORT: desc_done_o = 1 for one cycle with desc_done_id_o = id -> IDLE.
- Outstanding counter: +1 on ISSUE, -1 on wr_chunk_done_i. Both in the same cycle leave it unchanged. wr_chunk_done_i at outstanding 0 is ignored (no underflow).
- Address arithmetic: 32-bit modulo wrap at 0xFFFFFFFF; no error flag.
- run_i deasserted mid-descriptor: current chunk issue completes if already in ISSUE; thereafter the block holds in CHECK; DRAIN and REPORT still proceed.
- Command outputs are registered; addr/bytes are stable while req is high and 0 otherwise.
- Latency: accept -> first command push = 3 cycles (LOAD, CHECK, ISSUE) when not blocked.

Optional Feature:
DMA_4K_BOUNDARY_EN
- Defined: chunk = min(remaining, MAX_CHUNK_BYTES, 4096 - src[11:0], 4096 - dst[11:0]), so no command crosses a 4 KB boundary on either side.
- Undefined: chunk = min(remaining, MAX_CHUNK_BYTES) only.

Test Plan:
- Single chunk: src=0x1000, dst=0x8000, len=512, id=0x11; then one wr_chunk_done_i -> one push pair (0x1000/0x8000, 512); desc_done_o with id 0x11.
- Multi-chunk: len=2500, MAX_CHUNK_BYTES=1024 -> pushes of 1024, 1024, 452 at src, src+0x400, src+0x800; done only after the third completion.
- Backpressure: dma_wr_fifo_full_i high for 20 cycles during CHECK -> no rd or wr push in that window; both push in the same cycle after release.
- Outstanding limit: MAX_OUTSTANDING=2, len=4096, no completions -> exactly 2 pushes, then stall; each completion pulse releases one more push; a simultaneous issue and done keeps the count unchanged.
- Zero length: len=0, id=0x5A -> no command pushes; desc_done_o 3 cycles after accept.
- Boundary (DMA_4K_BOUNDARY_EN defined): src=0x0F80, dst=0x2000, len=1024 -> chunks of 128 then 896; with the macro undefined -> a single 1024-byte chunk.
- Reset mid-DRAIN: pull reset_n low -> all outputs 0 immediately; no desc_done_o is ever issued for that descriptor.

Source files
------------

// File: rtl/dma_desc_scheduler.sv
// Descriptor-to-command scheduler: splits each DMA descriptor into matched read/write
// command pairs, limits in-flight chunks and reports completion. Optional macro: DMA_4K_BOUNDARY_EN.
module dma_desc_scheduler #(
  parameter int MAX_CHUNK_BYTES = 1024,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic [31:0] desc_src_addr_i,
  input  logic [31:0] desc_dst_addr_i,
  input  logic [15:0] desc_length_i,
  input  logic [7:0]  desc_id_i,
  input  logic        run_i,
  output logic        dma_rd_fifo_command_req_o,
  output logic [31:0] dma_rd_addr_o,
  output logic [15:0] dma_rd_bytes_to_transfer_o,
  input  logic        dma_rd_fifo_full_i,
  output logic        dma_wr_fifo_command_req_o,
  output logic [31:0] dma_wr_addr_o,
  output logic [15:0] dma_wr_bytes_to_transfer_o,
  input  logic        dma_wr_fifo_full_i,
  input  logic        wr_chunk_done_i,
  output logic        desc_done_o,
  output logic [7:0]  desc_done_id_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    ISSUE  = 3'd3,
    DRAIN  = 3'd4,
    REPORT = 3'd5
  } state_t;

  localparam logic [15:0] MAX_CHUNK_C = 16'(MAX_CHUNK_BYTES);
  localparam logic [3:0]  MAX_OUT_C   = 4'(MAX_OUTSTANDING);

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] remaining_r;
  logic [15:0] chunk_r;
  logic [7:0]  id_r;
  logic [15:0] issued_r;
  logic [3:0]  outstanding_r;
  logic [15:0] chunk_next_s;
  logic        accept_s;
  logic        issue_ok_s;
  logic        cnt_inc_s;
  logic        cnt_dec_s;
  logic        cmd_push_s;
  logic        done_set_s;
  logic        busy_set_s;
  logic        rd_req_r;
  logic        wr_req_r;
  logic [31:0] rd_addr_r;
  logic [31:0] wr_addr_r;
  logic [15:0] rd_bytes_r;
  logic [15:0] wr_bytes_r;
  logic        done_r;
  logic [7:0]  done_id_r;
  logic        busy_r;

  assign accept_s   = reset_n & (state_r == IDLE) & run_i & desc_valid_i;
  assign issue_ok_s = run_i & ~dma_rd_fifo_full_i & ~dma_wr_fifo_full_i &
                      (outstanding_r < MAX_OUT_C);
  assign cnt_inc_s  = (state_r == ISSUE);
  assign cnt_dec_s  = wr_chunk_done_i & (outstanding_r != 4'd0);

`ifdef DMA_4K_BOUNDARY_EN
  logic [12:0] src_room_s;
  logic [12:0] dst_room_s;

  // Chunk size limited by descriptor, max chunk and the distance to the next 4 KB page on both sides
  always_comb begin
    src_room_s   = 13'h1000 - {1'b0, src_r[11:0]};
    dst_room_s   = 13'h1000 - {1'b0, dst_r[11:0]};
    chunk_next_s = min16(remaining_r, MAX_CHUNK_C);
    chunk_next_s = min16(chunk_next_s, {3'b000, src_room_s});
    chunk_next_s = min16(chunk_next_s, {3'b000, dst_room_s});
  end
`else
  // Chunk size limited by descriptor remainder and max chunk
  always_comb begin
    chunk_next_s = min16(remaining_r, MAX_CHUNK_C);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = LOAD;
        else          next_state_s = IDLE;
      end
      LOAD: begin
        if (remaining_r == 16'd0) next_state_s = REPORT;
        else                      next_state_s = CHECK;
      end
      CHECK: begin
        if (issue_ok_s) next_state_s = ISSUE;
        else            next_state_s = CHECK;
      end
      ISSUE: begin
        if (remaining_r == chunk_r) next_state_s = DRAIN;
        else                        next_state_s = LOAD;
      end
      DRAIN: begin
        if (outstanding_r == 4'd0) next_state_s = REPORT;
        else                       next_state_s = DRAIN;
      end
      REPORT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; commands and busy follow the next state so they line up with ISSUE
  always_comb begin
    cmd_push_s = (next_state_s == ISSUE);
    done_set_s = (state_r == REPORT);
    busy_set_s = (next_state_s != IDLE);
  end

  // Descriptor datapath: capture on accept, size in LOAD, advance in ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_r       <= 32'h0;
      dst_r       <= 32'h0;
      remaining_r <= 16'h0;
      chunk_r     <= 16'h0;
      id_r        <= 8'h0;
      issued_r    <= 16'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            src_r       <= desc_src_addr_i;
            dst_r       <= desc_dst_addr_i;
            remaining_r <= desc_length_i;
            id_r        <= desc_id_i;
            issued_r    <= 16'h0;
          end
        end
        LOAD: chunk_r <= chunk_next_s;
        ISSUE: begin
          src_r       <= src_r + {16'h0, chunk_r};
          dst_r       <= dst_r + {16'h0, chunk_r};
          remaining_r <= remaining_r - chunk_r;
          issued_r    <= issued_r + 16'd1;
        end
        default: begin
          chunk_r <= chunk_r;
        end
      endcase
    end
  end

  // In-flight chunk counter; a completion at zero is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_r <= 4'd0;
    end else begin
      case ({cnt_inc_s, cnt_dec_s})
        2'b10:   outstanding_r <= outstanding_r + 4'd1;
        2'b01:   outstanding_r <= outstanding_r - 4'd1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Registered outputs; address and size fields are zero whenever no push is active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_r   <= 1'b0;
      wr_req_r   <= 1'b0;
      rd_addr_r  <= 32'h0;
      wr_addr_r  <= 32'h0;
      rd_bytes_r <= 16'h0;
      wr_bytes_r <= 16'h0;
      done_r     <= 1'b0;
      done_id_r  <= 8'h0;
      busy_r     <= 1'b0;
    end else begin
      rd_req_r   <= cmd_push_s;
      wr_req_r   <= cmd_push_s;
      rd_addr_r  <= cmd_push_s ? src_r : 32'h0;
      wr_addr_r  <= cmd_push_s ? dst_r : 32'h0;
      rd_bytes_r <= cmd_push_s ? chunk_r : 16'h0;
      wr_bytes_r <= cmd_push_s ? chunk_r : 16'h0;
      done_r     <= done_set_s;
      done_id_r  <= done_set_s ? id_r : 8'h0;
      busy_r     <= busy_set_s;
    end
  end

  assign desc_ready_o               = accept_s;
  assign dma_rd_fifo_command_req_o  = rd_req_r;
  assign dma_rd_addr_o              = rd_addr_r;
  assign dma_rd_bytes_to_transfer_o = rd_bytes_r;
  assign dma_wr_fifo_command_req_o  = wr_req_r;
  assign dma_wr_addr_o              = wr_addr_r;
  assign dma_wr_bytes_to_transfer_o = wr_bytes_r;
  assign desc_done_o                = done_r;
  assign desc_done_id_o             = done_id_r;
  assign busy_o                     = busy_r;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed bench for dma_desc_scheduler (MAX_CHUNK_BYTES=1024, MAX_OUTSTANDING=2).
module tb_dma_desc_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic [31:0] desc_src_addr_i = 32'h0;
  logic [31:0] desc_dst_addr_i = 32'h0;
  logic [15:0] desc_length_i = 16'h0;
  logic [7:0]  desc_id_i = 8'h0;
  logic        run_i = 1'b0;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr;
  logic [15:0] rd_bytes, wr_bytes;
  logic        rd_full = 1'b0;
  logic        wr_full = 1'b0;
  logic        wr_chunk_done_i = 1'b0;
  logic        desc_done_o;
  logic [7:0]  desc_done_id_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_bad = 0;

  typedef struct {int c; logic [31:0] addr; logic [15:0] bytes;} push_t;
  push_t      rd_q[$];
  push_t      wr_q[$];
  int         done_cyc_q[$];
  logic [7:0] done_id_q[$];

  dma_desc_scheduler #(.MAX_CHUNK_BYTES(1024), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
    .desc_length_i(desc_length_i), .desc_id_i(desc_id_i), .run_i(run_i),
    .dma_rd_fifo_command_req_o(rd_req), .dma_rd_addr_o(rd_addr),
    .dma_rd_bytes_to_transfer_o(rd_bytes), .dma_rd_fifo_full_i(rd_full),
    .dma_wr_fifo_command_req_o(wr_req), .dma_wr_addr_o(wr_addr),
    .dma_wr_bytes_to_transfer_o(wr_bytes), .dma_wr_fifo_full_i(wr_full),
    .wr_chunk_done_i(wr_chunk_done_i), .desc_done_o(desc_done_o),
    .desc_done_id_o(desc_done_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Push and done logger, sampled on the falling edge
  always @(negedge clk) begin
    if (rd_req) rd_q.push_back('{cyc, rd_addr, rd_bytes});
    else if (rd_addr !== 32'h0 || rd_bytes !== 16'h0) idle_bad++;
    if (wr_req) wr_q.push_back('{cyc, wr_addr, wr_bytes});
    else if (wr_addr !== 32'h0 || wr_bytes !== 16'h0) idle_bad++;
    if (desc_done_o) begin
      done_cyc_q.push_back(cyc);
      done_id_q.push_back(desc_done_id_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); done_cyc_q.delete(); done_id_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 wr_chunk_done_i = 1'b1;
    @(posedge clk); #1 wr_chunk_done_i = 1'b0;
  endtask

  task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                           input logic [7:0] id, output int acc);
    @(posedge clk); #1;
    desc_valid_i = 1'b1; desc_src_addr_i = s; desc_dst_addr_i = d;
    desc_length_i = len; desc_id_i = id;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (desc_ready_o) acc = cyc;
    end
    @(posedge clk); #1 desc_valid_i = 1'b0;
    checks++;
    if (acc < 0) begin errors++; $display("FAIL accept id %h: desc_ready_o stayed 0, required 1", id); end
  endtask

  task automatic wait_pushes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (rd_q.size() >= n) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_desc_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_id_q.size() > 0) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    run_i = 1'b1; desc_valid_i = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    checks++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL reset req: rd %b wr %b, required 0", rd_req, wr_req); end
    checks++; if (desc_done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset done/busy: %b/%b, required 0/0", desc_done_o, busy_o); end
    checks++; if (desc_ready_o !== 1'b0) begin errors++; $display("FAIL reset ready: %b, required 0", desc_ready_o); end
    @(negedge clk); reset_n = 1'b1;
    #1;
    checks++; if (desc_ready_o !== 1'b1) begin errors++; $display("FAIL idle ready: %b, required 1", desc_ready_o); end
    run_i = 1'b0;
    #1;
    checks++; if (desc_ready_o !== 1'b0) begin errors++; $display("FAIL ready with run low: %b, required 0", desc_ready_o); end
    desc_valid_i = 1'b0; run_i = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single();
    int acc; bit ok;
    clear_logs();
    send_desc(32'h0000_1000, 32'h0000_8000, 16'd512, 8'h11, acc);
    wait_cycles(8);
    checks++; if (rd_q.size() != 1 || wr_q.size() != 1) begin errors++; $display("FAIL single count: rd %0d wr %0d, required 1/1", rd_q.size(), wr_q.size()); end
    else begin
      checks++; if (rd_q[0].addr !== 32'h1000 || wr_q[0].addr !== 32'h8000) begin errors++; $display("FAIL single addr: %h/%h, required 00001000/00008000", rd_q[0].addr, wr_q[0].addr); end
      checks++; if (rd_q[0].bytes !== 16'd512 || wr_q[0].bytes !== 16'd512) begin errors++; $display("FAIL single bytes: %0d/%0d, required 512", rd_q[0].bytes, wr_q[0].bytes); end
      checks++; if (rd_q[0].c != acc + 3 || wr_q[0].c != acc + 3) begin errors++; $display("FAIL single latency: %0d cycles, required 3", rd_q[0].c - acc); end
    end
    checks++; if (done_id_q.size() != 0 || busy_o !== 1'b1) begin errors++; $display("FAIL single early done: dones %0d busy %b, required 0/1", done_id_q.size(), busy_o); end
    pulse_done();
    wait_desc_done(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single done: no desc_done_o, required pulse"); end
    else begin
      checks++; if (done_id_q[0] !== 8'h11) begin errors++; $display("FAIL single id: %h, required 11", done_id_q[0]); end
    end
    wait_cycles(2);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single idle busy: %b, required 0", busy_o); end
  endtask

  task automatic test_multi();
    int acc; bit ok;
    logic [15:0] exp_b [3];
    exp_b[0] = 16'd1024; exp_b[1] = 16'd1024; exp_b[2] = 16'd452;
    clear_logs();
    send_desc(32'h0002_0000, 32'h0003_0000, 16'd2500, 8'h22, acc);
    wait_pushes(2, 20, ok);
    wait_cycles(5);
    checks++; if (rd_q.size() != 2) begin errors++; $display("FAIL multi stall: %0d pushes, required 2", rd_q.size()); end
    pulse_done();
    wait_pushes(3, 20, ok);
    wait_cycles(3);
    pulse_done();
    wait_cycles(5);
    checks++; if (done_id_q.size() != 0) begin errors++; $display("FAIL multi early done: %0d dones, required 0", done_id_q.size()); end
    pulse_done();
    wait_desc_done(20, ok);
    checks++; if (!ok || done_id_q[0] !== 8'h22) begin errors++; $display("FAIL multi done: seen %b, required id 22", ok); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rd_q.size() || i >= wr_q.size()) begin errors++; $display("FAIL multi push %0d: missing, %0d pushes seen", i, rd_q.size()); end
      else if (rd_q[i].addr !== 32'h0002_0000 + 32'(i * 1024) || wr_q[i].addr !== 32'h0003_0000 + 32'(i * 1024) ||
               rd_q[i].bytes !== exp_b[i] || wr_q[i].bytes !== exp_b[i] || rd_q[i].c != wr_q[i].c) begin
        errors++; $display("FAIL multi push %0d: rd %h/%0d wr %h/%0d, required bytes %0d", i, rd_q[i].addr, rd_q[i].bytes, wr_q[i].addr, wr_q[i].bytes, exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc; bit ok;
    clear_logs();
    wr_full = 1'b1;
    send_desc(32'h0000_4000, 32'h0000_5000, 16'd256, 8'h33, acc);
    wait_cycles(20);
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL backpressure: rd %0d wr %0d pushes while full, required 0", rd_q.size(), wr_q.size()); end
    wr_full = 1'b0;
    wait_pushes(1, 10, ok);
    checks++; if (rd_q.size() != 1 || wr_q.size() != 1) begin errors++; $display("FAIL release count: rd %0d wr %0d, required 1/1", rd_q.size(), wr_q.size()); end
    else begin
      checks++; if (rd_q[0].c != wr_q[0].c || rd_q[0].bytes !== 16'd256 || wr_q[0].bytes !== 16'd256) begin errors++; $display("FAIL release pair: cyc %0d/%0d bytes %0d/%0d, required same cycle 256", rd_q[0].c, wr_q[0].c, rd_q[0].bytes, wr_q[0].bytes); end
    end
    pulse_done();
    wait_desc_done(20, ok);
    checks++; if (!ok || done_id_q[0] !== 8'h33) begin errors++; $display("FAIL backpressure done: seen %b, required id 33", ok); end
  endtask

  task automatic test_outstanding();
    int acc; int w0; bit ok;
    clear_logs();
    send_desc(32'h0001_0000, 32'h0002_0000, 16'd4096, 8'h44, acc);
    wait_cycles(20);
    checks++; if (rd_q.size() != 2) begin errors++; $display("FAIL limit stall: %0d pushes, required 2", rd_q.size()); end
    pulse_done();
    wait_pushes(3, 20, ok);
    wait_cycles(5);
    checks++; if (rd_q.size() != 3) begin errors++; $display("FAIL limit release: %0d pushes, required 3", rd_q.size()); end
    @(posedge clk); #1 wr_chunk_done_i = 1'b1; w0 = cyc;
    @(posedge clk); #1 wr_chunk_done_i = 1'b0;
    @(posedge clk); #1 wr_chunk_done_i = 1'b1;
    @(posedge clk); #1 wr_chunk_done_i = 1'b0;
    wait_cycles(8);
    checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL limit fourth: %0d pushes, required 4", rd_q.size()); end
    else begin
      checks++; if (rd_q[3].c != w0 + 2) begin errors++; $display("FAIL limit timing: push at %0d, required %0d", rd_q[3].c, w0 + 2); end
    end
    checks++; if (done_id_q.size() != 0) begin errors++; $display("FAIL simultaneous issue/done: %0d dones, required 0", done_id_q.size()); end
    pulse_done();
    wait_desc_done(20, ok);
    checks++; if (!ok || done_id_q[0] !== 8'h44) begin errors++; $display("FAIL limit done: seen %b, required id 44", ok); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_q.size() || i >= wr_q.size()) begin errors++; $display("FAIL limit push %0d: missing", i); end
      else if (rd_q[i].addr !== 32'h0001_0000 + 32'(i * 1024) || wr_q[i].addr !== 32'h0002_0000 + 32'(i * 1024) ||
               rd_q[i].bytes !== 16'd1024 || wr_q[i].bytes !== 16'd1024) begin
        errors++; $display("FAIL limit push %0d: rd %h/%0d wr %h/%0d, required 1024 bytes", i, rd_q[i].addr, rd_q[i].bytes, wr_q[i].addr, wr_q[i].bytes);
      end
    end
  endtask

  task automatic test_zero_length();
    int acc; bit ok;
    clear_logs();
    send_desc(32'h0000_0100, 32'h0000_0200, 16'd0, 8'h5A, acc);
    wait_desc_done(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero done: no desc_done_o, required pulse"); end
    else begin
      checks++; if (done_cyc_q[0] != acc + 3) begin errors++; $display("FAIL zero latency: %0d cycles, required 3", done_cyc_q[0] - acc); end
      checks++; if (done_id_q[0] !== 8'h5A) begin errors++; $display("FAIL zero id: %h, required 5a", done_id_q[0]); end
    end
    wait_cycles(3);
    checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL zero pushes: %0d/%0d, required 0", rd_q.size(), wr_q.size()); end
  endtask

  task automatic run_table(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                           input logic [7:0] id, input int n_exp, input logic [31:0] es [2],
                           input logic [31:0] ed [2], input logic [15:0] eb [2]);
    int acc; bit ok;
    clear_logs();
    send_desc(s, d, len, id, acc);
    wait_pushes(n_exp, 20, ok);
    for (int i = 0; i < n_exp; i++) pulse_done();
    wait_desc_done(20, ok);
    checks++; if (!ok || done_id_q[0] !== id) begin errors++; $display("FAIL table id %h done: seen %b, required pulse", id, ok); end
    checks++; if (rd_q.size() != n_exp || wr_q.size() != n_exp) begin errors++; $display("FAIL table id %h count: %0d/%0d, required %0d", id, rd_q.size(), wr_q.size(), n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      checks++;
      if (i >= rd_q.size() || i >= wr_q.size()) begin errors++; $display("FAIL table id %h push %0d: missing", id, i); end
      else if (rd_q[i].addr !== es[i] || wr_q[i].addr !== ed[i] || rd_q[i].bytes !== eb[i] || wr_q[i].bytes !== eb[i]) begin
        errors++; $display("FAIL table id %h push %0d: rd %h/%0d wr %h/%0d, required %h/%h/%0d", id, i, rd_q[i].addr, rd_q[i].bytes, wr_q[i].addr, wr_q[i].bytes, es[i], ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] es [2]; logic [31:0] ed [2]; logic [15:0] eb [2];
`ifdef DMA_4K_BOUNDARY_EN
    es[0] = 32'h0000_0F80; ed[0] = 32'h0000_2000; eb[0] = 16'd128;
    es[1] = 32'h0000_1000; ed[1] = 32'h0000_2080; eb[1] = 16'd896;
    run_table(32'h0000_0F80, 32'h0000_2000, 16'd1024, 8'h66, 2, es, ed, eb);
`else
    es[0] = 32'h0000_0F80; ed[0] = 32'h0000_2000; eb[0] = 16'd1024;
    es[1] = 32'h0; ed[1] = 32'h0; eb[1] = 16'd0;
    run_table(32'h0000_0F80, 32'h0000_2000, 16'd1024, 8'h66, 1, es, ed, eb);
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] es [2]; logic [31:0] ed [2]; logic [15:0] eb [2];
    es[0] = 32'hFFFF_FC00; ed[0] = 32'h0000_0100; eb[0] = 16'd1024;
    es[1] = 32'h0000_0000; ed[1] = 32'h0000_0500; eb[1] = 16'd1024;
    run_table(32'hFFFF_FC00, 32'h0000_0100, 16'd2048, 8'h77, 2, es, ed, eb);
  endtask

  task automatic test_reset_drain();
    int acc; bit ok;
    clear_logs();
    send_desc(32'h0000_9000, 32'h0000_A000, 16'd512, 8'h88, acc);
    wait_pushes(1, 20, ok);
    wait_cycles(3);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL drain busy: %b, required 1", busy_o); end
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0 || desc_done_o !== 1'b0) begin
      errors++; $display("FAIL async reset: busy %b rd %b wr %b done %b, required 0", busy_o, rd_req, wr_req, desc_done_o);
    end
    wait_cycles(3);
    reset_n = 1'b1;
    pulse_done();
    wait_cycles(15);
    checks++; if (done_id_q.size() != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL abandoned desc: dones %0d busy %b, required 0/0", done_id_q.size(), busy_o); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle fields: %0d nonzero samples, required 0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_outstanding();
    test_zero_length();
    test_boundary();
    test_wrap();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
